// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V main controller.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction and data memory, counts retired instructions, and stops the
// core on HALT, an illegal opcode, or a data-memory access that never completes.
module multicycle_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_opcode,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_alu_src,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [1:0]       o_alu_op,
  output logic             o_branch,
  output logic             o_halt,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_retired
);

  // Instruction opcodes recognised by the core
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  // ALU operation classes
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_JUMP = 2'b11;

  // A timeout of zero means the MEM state waits forever for dmem_ready.
  localparam bit             TO_EN        = (MEM_TIMEOUT != 0);
  localparam int             TO_LIMIT_INT = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(TO_LIMIT_INT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [6:0]        r_opcodeQ;
  logic [TO_W-1:0]   r_toCount;
  logic              r_trap;
  logic [CNT_W-1:0]  r_retired;
  logic              w_setTrap;

  // Class flags for the latched opcode (used from EXEC onwards)
  logic w_isR, w_isLw, w_isSw, w_isBr, w_isI, w_isJal, w_isJalr;
  logic w_isMemOp, w_isJump;
  logic [1:0] w_aluOpQ;

  // Class flags for the live opcode (used only while in DECODE)
  logic w_inIsHalt, w_inIsLegal;

  assign w_isR     = (r_opcodeQ == OP_R);
  assign w_isLw    = (r_opcodeQ == OP_LW);
  assign w_isSw    = (r_opcodeQ == OP_SW);
  assign w_isBr    = (r_opcodeQ == OP_BR);
  assign w_isI     = (r_opcodeQ == OP_I);
  assign w_isJal   = (r_opcodeQ == OP_JAL);
  assign w_isJalr  = (r_opcodeQ == OP_JALR);
  assign w_isMemOp = w_isLw | w_isSw;
  assign w_isJump  = w_isJal | w_isJalr;

  assign w_inIsHalt  = (i_opcode == OP_HALT);
  assign w_inIsLegal = (i_opcode == OP_R)  || (i_opcode == OP_LW)  ||
                       (i_opcode == OP_SW) || (i_opcode == OP_BR)  ||
                       (i_opcode == OP_I)  || (i_opcode == OP_JAL) ||
                       (i_opcode == OP_JALR);

  // ALU operation selected by the latched opcode class
  always_comb begin
    w_aluOpQ = ALU_ADD;
    if (w_isBr) begin
      w_aluOpQ = ALU_BR;
    end else if (w_isR || w_isI) begin
      w_aluOpQ = ALU_FUNC;
    end else if (w_isJump) begin
      w_aluOpQ = ALU_JUMP;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection; also flags the two ways of entering HALTED with a trap
  always_comb begin
    w_nextState = r_state;
    w_setTrap   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_nextState = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_imem_ready) begin
          w_nextState = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_inIsHalt) begin
          w_nextState = ST_HALTED;
        end else if (!w_inIsLegal) begin
          w_nextState = ST_HALTED;
          w_setTrap   = 1'b1;
        end else begin
          w_nextState = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_isMemOp) begin
          w_nextState = ST_MEM;
        end else if (w_isBr) begin
          w_nextState = ST_FETCH;
        end else begin
          w_nextState = ST_WB;
        end
      end
      ST_MEM: begin
        if (i_dmem_ready) begin
          w_nextState = w_isLw ? ST_WB : ST_FETCH;
        end else if (TO_EN && (r_toCount == TO_LIMIT)) begin
          w_nextState = ST_HALTED;
          w_setTrap   = 1'b1;
        end
      end
      ST_WB: begin
        w_nextState = ST_FETCH;
      end
      ST_HALTED: begin
        w_nextState = ST_HALTED;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Moore control outputs decoded from state and latched opcode
  always_comb begin
    o_imem_req   = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_alu_op     = ALU_ADD;
    o_branch     = 1'b0;
    o_halt       = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_write = i_imem_ready;
      end
      ST_EXEC: begin
        o_alu_src = w_isMemOp | w_isI;
        o_alu_op  = w_aluOpQ;
        if (w_isBr) begin
          o_branch   = 1'b1;
          o_pc_write = 1'b1;
        end
      end
      ST_MEM: begin
        o_mem_read  = w_isLw;
        o_mem_write = w_isSw;
        o_pc_write  = w_isSw & i_dmem_ready;
      end
      ST_WB: begin
        o_reg_write  = 1'b1;
        o_pc_write   = 1'b1;
        o_mem_to_reg = w_isLw;
        o_alu_op     = w_aluOpQ;
        o_branch     = w_isJump;
      end
      ST_HALTED: begin
        o_halt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Capture the opcode once per instruction, at the end of DECODE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opcodeQ <= 7'd0;
    end else if (r_state == ST_DECODE) begin
      r_opcodeQ <= i_opcode;
    end
  end

  // Count MEM cycles spent waiting; restarted on every EXEC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_toCount <= '0;
    end else if (r_state == ST_EXEC) begin
      r_toCount <= '0;
    end else if ((r_state == ST_MEM) && !i_dmem_ready) begin
      r_toCount <= r_toCount + TO_W'(1);
    end
  end

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trap <= 1'b0;
    end else if (w_setTrap) begin
      r_trap <= 1'b1;
    end
  end

  // Retired-instruction counter, one tick per PC update, wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired <= '0;
    end else if (o_pc_write) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_trap    = r_trap;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: drives whole instructions with random
// memory latencies and compares every cycle against an instruction-level model.
module tb_multicycle_controller;

  localparam int TB_TO = 16;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef struct packed {
    logic       imemReq;
    logic       irWrite;
    logic       pcWrite;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] aluOp;
    logic       branch;
    logic       halt;
    logic       trap;
  } ctrl_t;

  logic       clk;
  logic       rstN;
  logic [6:0] opcode;
  logic       imemReady;
  logic       dmemReady;

  logic imemReqA, irWriteA, pcWriteA, aluSrcA, memToRegA, regWriteA, memReadA, memWriteA;
  logic branchA, haltA, trapA;
  logic [1:0]  aluOpA;
  logic [31:0] retiredA;
  logic imemReqB, irWriteB, pcWriteB, aluSrcB, memToRegB, regWriteB, memReadB, memWriteB;
  logic branchB, haltB, trapB;
  logic [1:0]  aluOpB;
  logic [3:0]  retiredB;

  ctrl_t outA, outB;
  assign outA = {imemReqA, irWriteA, pcWriteA, aluSrcA, memToRegA, regWriteA,
                 memReadA, memWriteA, aluOpA, branchA, haltA, trapA};
  assign outB = {imemReqB, irWriteB, pcWriteB, aluSrcB, memToRegB, regWriteB,
                 memReadB, memWriteB, aluOpB, branchB, haltB, trapB};

  multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(TB_TO), .TO_W(8)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_opcode(opcode),
    .i_imem_ready(imemReady), .i_dmem_ready(dmemReady),
    .o_imem_req(imemReqA), .o_ir_write(irWriteA), .o_pc_write(pcWriteA),
    .o_alu_src(aluSrcA), .o_mem_to_reg(memToRegA), .o_reg_write(regWriteA),
    .o_mem_read(memReadA), .o_mem_write(memWriteA), .o_alu_op(aluOpA),
    .o_branch(branchA), .o_halt(haltA), .o_trap(trapA), .o_retired(retiredA)
  );

  // Narrow-counter instance sharing the same stimulus, to exercise wrap-around
  multicycle_controller #(.CNT_W(4), .MEM_TIMEOUT(TB_TO), .TO_W(8)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_opcode(opcode),
    .i_imem_ready(imemReady), .i_dmem_ready(dmemReady),
    .o_imem_req(imemReqB), .o_ir_write(irWriteB), .o_pc_write(pcWriteB),
    .o_alu_src(aluSrcB), .o_mem_to_reg(memToRegB), .o_reg_write(regWriteB),
    .o_mem_read(memReadB), .o_mem_write(memWriteB), .o_alu_op(aluOpB),
    .o_branch(branchB), .o_halt(haltB), .o_trap(trapB), .o_retired(retiredB)
  );

  int errors;
  int checks;
  int memActive;

  // Model state: expected outputs per cycle plus instruction-level bookkeeping
  ctrl_t       expQ[$];
  logic [31:0] expRetQ[$];
  logic [31:0] modelRet;
  logic        modelTrap;
  logic        modelStopped;
  logic        modelAborted;

  ctrl_t       cmpExp;
  logic [31:0] cmpRet;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) begin
        $display("[TB] FAIL %s: actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
    end
  endtask

  task automatic compareVec(input string tag, input ctrl_t act, input ctrl_t exp);
    checkOutput($sformatf("%s.imem_req", tag),   32'(act.imemReq),  32'(exp.imemReq));
    checkOutput($sformatf("%s.ir_write", tag),   32'(act.irWrite),  32'(exp.irWrite));
    checkOutput($sformatf("%s.pc_write", tag),   32'(act.pcWrite),  32'(exp.pcWrite));
    checkOutput($sformatf("%s.alu_src", tag),    32'(act.aluSrc),   32'(exp.aluSrc));
    checkOutput($sformatf("%s.mem_to_reg", tag), 32'(act.memToReg), 32'(exp.memToReg));
    checkOutput($sformatf("%s.reg_write", tag),  32'(act.regWrite), 32'(exp.regWrite));
    checkOutput($sformatf("%s.mem_read", tag),   32'(act.memRead),  32'(exp.memRead));
    checkOutput($sformatf("%s.mem_write", tag),  32'(act.memWrite), 32'(exp.memWrite));
    checkOutput($sformatf("%s.alu_op", tag),     32'(act.aluOp),    32'(exp.aluOp));
    checkOutput($sformatf("%s.branch", tag),     32'(act.branch),   32'(exp.branch));
    checkOutput($sformatf("%s.halt", tag),       32'(act.halt),     32'(exp.halt));
    checkOutput($sformatf("%s.trap", tag),       32'(act.trap),     32'(exp.trap));
  endtask

  // Compare process: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      cmpExp = expQ.pop_front();
      cmpRet = expRetQ.pop_front();
      compareVec("A", outA, cmpExp);
      compareVec("B", outB, cmpExp);
      checkOutput("retired", retiredA, cmpRet);
      checkOutput("retired4", {28'd0, retiredB}, {28'd0, cmpRet[3:0]});
    end
    if (memReadA || memWriteA) memActive++;
  end

  function automatic logic rb();
    return 1'($urandom());
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom());
  endfunction

  function automatic logic isLegal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BR) ||
           (op == OP_I) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic [1:0] aluOpOf(input logic [6:0] op);
    if (op == OP_BR) return 2'b01;
    if (op == OP_R || op == OP_I) return 2'b10;
    if (op == OP_JAL || op == OP_JALR) return 2'b11;
    return 2'b00;
  endfunction

  // Drive one cycle of inputs and record what the outputs must be during it
  task automatic applyStimulus(input logic rst, input logic iRdy, input logic dRdy,
                               input logic [6:0] op, input ctrl_t e);
    rstN      = rst;
    imemReady = iRdy;
    dmemReady = dRdy;
    opcode    = op;
    if (!rst) modelRet = 32'd0;
    expQ.push_back(e);
    expRetQ.push_back(modelRet);
    if (e.pcWrite) modelRet = modelRet + 32'd1;
    @(posedge clk);
    #1;
  endtask

  // Reset for n cycles, then one IDLE cycle; the next cycle is FETCH
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, rb(), rb(), ro(), '0);
    modelTrap = 1'b0;
    applyStimulus(1'b1, rb(), rb(), ro(), '0);
  endtask

  task automatic runHalted(input int n);
    ctrl_t e;
    e      = '0;
    e.halt = 1'b1;
    e.trap = modelTrap;
    for (int i = 0; i < n; i++) applyStimulus(1'b1, rb(), rb(), ro(), e);
  endtask

  // One instruction from FETCH entry; memory completes after dmemWait stalls,
  // and abortAt >= 0 asserts reset in that MEM cycle.
  task automatic runInstr(input logic [6:0] op, input int imemWait, input int dmemWait,
                          input int abortAt, output int cycles);
    ctrl_t e;
    logic  rdy;
    logic  isLw, isSw;
    isLw = (op == OP_LW);
    isSw = (op == OP_SW);
    cycles = 0;
    modelStopped = 1'b0;
    modelAborted = 1'b0;
    for (int i = 0; i < imemWait; i++) begin
      e = '0; e.imemReq = 1'b1;
      applyStimulus(1'b1, 1'b0, rb(), ro(), e); cycles++;
    end
    e = '0; e.imemReq = 1'b1; e.irWrite = 1'b1;
    applyStimulus(1'b1, 1'b1, rb(), ro(), e); cycles++;
    e = '0;
    applyStimulus(1'b1, rb(), rb(), op, e); cycles++;
    if (op == OP_HALT || !isLegal(op)) begin
      modelStopped = 1'b1;
      modelTrap    = (op != OP_HALT);
      return;
    end
    e = '0;
    e.aluOp  = aluOpOf(op);
    e.aluSrc = isLw || isSw || (op == OP_I);
    if (op == OP_BR) begin
      e.branch = 1'b1; e.pcWrite = 1'b1;
    end
    applyStimulus(1'b1, rb(), rb(), ro(), e); cycles++;
    if (op == OP_BR) return;
    if (isLw || isSw) begin
      for (int k = 0; k < TB_TO; k++) begin
        if (k == abortAt) begin
          rstN = 1'b0;
          #1;
          checkOutput("abort_outputs", 32'(outA), 32'd0);
          checkOutput("abort_retired", retiredA, 32'd0);
          applyStimulus(1'b0, rb(), rb(), ro(), '0);
          modelAborted = 1'b1;
          return;
        end
        rdy = (k == dmemWait);
        e = '0;
        e.memRead  = isLw;
        e.memWrite = isSw;
        e.pcWrite  = isSw && rdy;
        applyStimulus(1'b1, rb(), rdy, ro(), e); cycles++;
        if (rdy) break;
        if (k == TB_TO - 1) begin
          modelStopped = 1'b1;
          modelTrap    = 1'b1;
          return;
        end
      end
      if (isSw) return;
    end
    e = '0;
    e.regWrite = 1'b1;
    e.pcWrite  = 1'b1;
    e.memToReg = isLw;
    e.aluOp    = aluOpOf(op);
    e.branch   = (op == OP_JAL) || (op == OP_JALR);
    applyStimulus(1'b1, rb(), rb(), ro(), e); cycles++;
  endtask

  function automatic logic [6:0] pickOp();
    logic [6:0] legalOps [7];
    logic [6:0] x;
    int r;
    legalOps = '{OP_R, OP_LW, OP_SW, OP_BR, OP_I, OP_JAL, OP_JALR};
    r = $urandom_range(0, 15);
    if (r < 14) return legalOps[r % 7];
    if (r == 14) return OP_HALT;
    for (int t = 0; t < 50; t++) begin
      x = ro();
      if (!isLegal(x) && x != OP_HALT) return x;
    end
    return 7'h00;
  endfunction

  initial begin
    int cyc;
    int iw, dw, ab, sel;
    logic [6:0] op;
    errors = 0; checks = 0; memActive = 0;
    modelRet = 32'd0; modelTrap = 1'b0; modelStopped = 1'b0; modelAborted = 1'b0;
    rstN = 1'b0; imemReady = 1'b0; dmemReady = 1'b0; opcode = 7'd0;
    @(posedge clk);
    #1;
    doReset(2);

    runInstr(OP_R, 0, 0, -1, cyc);
    checkOutput("r_cycles", cyc, 32'd4);
    checkOutput("r_retired", retiredA, 32'd1);

    memActive = 0;
    runInstr(OP_LW, 0, 3, -1, cyc);
    checkOutput("lw_cycles", cyc, 32'd8);
    checkOutput("lw_mem_read_cycles", memActive, 32'd4);
    checkOutput("lw_retired", retiredA, 32'd2);

    runInstr(OP_BR, 0, 0, -1, cyc);
    checkOutput("br_cycles", cyc, 32'd3);
    checkOutput("br_retired", retiredA, 32'd3);

    memActive = 0;
    runInstr(OP_LW, 1, TB_TO - 1, -1, cyc);
    checkOutput("lw_limit_cycles", cyc, 32'd21);
    checkOutput("lw_limit_mem_cycles", memActive, 32'd16);
    checkOutput("lw_limit_retired", retiredA, 32'd4);

    memActive = 0;
    runInstr(OP_SW, 0, 1000, -1, cyc);
    runHalted(6);
    checkOutput("sw_to_mem_write_cycles", memActive, 32'd16);
    checkOutput("sw_to_halt", 32'(haltA), 32'd1);
    checkOutput("sw_to_trap", 32'(trapA), 32'd1);
    checkOutput("sw_to_retired", retiredA, 32'd4);
    doReset(1);
    checkOutput("sw_to_reset_retired", retiredA, 32'd0);

    runInstr(OP_R, 0, 0, -1, cyc);
    runInstr(OP_HALT, 2, 0, -1, cyc);
    runHalted(4);
    checkOutput("halt_halt", 32'(haltA), 32'd1);
    checkOutput("halt_trap", 32'(trapA), 32'd0);
    checkOutput("halt_retired", retiredA, 32'd1);
    doReset(1);
    checkOutput("halt_reset_retired", retiredA, 32'd0);

    runInstr(OP_JAL, 0, 0, -1, cyc);
    runInstr(7'h00, 0, 0, -1, cyc);
    runHalted(3);
    checkOutput("illegal_halt", 32'(haltA), 32'd1);
    checkOutput("illegal_trap", 32'(trapA), 32'd1);
    doReset(1);
    checkOutput("illegal_reset_retired", retiredA, 32'd0);
    checkOutput("illegal_reset_trap", 32'(trapA), 32'd0);

    for (int n = 0; n < 17; n++) runInstr(OP_I, 0, 0, -1, cyc);
    checkOutput("wrap_retired4", {28'd0, retiredB}, 32'd1);
    checkOutput("wrap_retired32", retiredA, 32'd17);

    runInstr(OP_LW, 0, 3, 1, cyc);
    doReset(1);

    for (int n = 0; n < 250; n++) begin
      op  = pickOp();
      iw  = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel < 6)       dw = $urandom_range(0, 3);
      else if (sel < 8)  dw = $urandom_range(4, 15);
      else if (sel == 8) dw = TB_TO - 1;
      else               dw = 40;
      ab = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
      runInstr(op, iw, dw, ab, cyc);
      if (modelAborted) begin
        doReset(1);
      end else if (modelStopped) begin
        runHalted($urandom_range(1, 4));
        doReset($urandom_range(1, 2));
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle main decoder of the RISC-V core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory.
- Drives the same datapath control set as the single-cycle decoder, plus per-cycle PC/IR write enables, a retired-instruction counter, and a data-memory timeout trap.
- Sits between the IR opcode field and the datapath/memory interface.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 16, max cycles to wait for dmem_ready in MEM; 0 disables timeout.
- TO_W, 8, width of timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from the cycle after ir_write.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access completes this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR this cycle.
- pc_write  out  1  update PC this cycle (instruction retires).
- alu_src  out  1  0: rs2, 1: immediate.
- mem_to_reg  out  1  write-back source is data memory.
- reg_write  out  1  register file write enable.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- alu_op  out  2  00 LW/SW, 01 branch, 10 R/I-type, 11 JAL/JALR.
- branch  out  1  PC source is branch/jump target.
- halt  out  1  core stopped.
- trap  out  1  stopped due to illegal opcode or memory timeout.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE, opcode_q=0, retired=0, timeout count=0, trap=0.
  - All outputs 0 while in reset and in IDLE.
- Opcodes: R=0110011, LW=0000011, SW=0100011, BR=1100011, I=0010011, JAL=1101111, JALR=1100111, HALT=1111111. Any other value is illegal.
- Outputs are Moore functions of state and opcode_q. opcode_q latches opcode on the DECODE clock edge; later changes to opcode are ignored until the next DECODE.
- IDLE: next cycle goes to FETCH unconditionally.
- FETCH:
  - imem_req=1.
  - ir_write = imem_ready.
  - imem_ready=1 -> DECODE; else stay.
- DECODE: all outputs 0; latch opcode_q.
  - HALT -> HALTED, trap=0.
  - Illegal -> HALTED, trap=1.
  - Otherwise -> EXEC.
- EXEC: alu_src=1 for LW/SW/I; alu_op per the table above.
  - R/I/JAL/JALR -> WB.
  - LW/SW -> MEM; timeout count cleared.
  - BR: branch=1, pc_write=1 -> FETCH.
- MEM:
  - mem_read=1 for LW, mem_write=1 for SW, held until dmem_ready.
  - On dmem_ready: LW -> WB; SW asserts pc_write -> FETCH.
  - Each cycle without dmem_ready increments the timeout count. When MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT-1 without ready -> HALTED, trap=1, no pc_write.
  - dmem_ready in the same cycle the limit is hit takes priority: the access completes normally.
- WB:
  - reg_write=1, pc_write=1.
  - mem_to_reg=1 for LW.
  - alu_op per opcode; branch=1 for JAL/JALR.
  - -> FETCH.
- HALTED: absorbing; halt=1; all other control outputs 0. Only reset exits.
- retired: +1 on every cycle pc_write=1; wraps modulo 2^CNT_W. HALT instructions and trapped instructions do not count.
- Cycles per instruction with zero-wait memory: R/I/JAL/JALR 4, BR 3, SW 4, LW 5 (FETCH..WB).
- Reset asserted mid-instruction: immediate return to IDLE; any in-flight memory request drops the same cycle.

Test Plan:
- Reset release, imem_ready=1, opcode=0110011 -> IDLE 1 cycle; imem_req=1 with ir_write=1 in FETCH; 4th cycle after FETCH entry shows reg_write=1, pc_write=1, alu_op=10; retired=1.
- LW with dmem_ready delayed 3 cycles -> mem_read held 4 cycles; WB shows mem_to_reg=1, reg_write=1; total 8 cycles; retired increments once.
- BR (1100011) -> EXEC cycle has branch=1, pc_write=1, alu_op=01, reg_write=0; next state FETCH.
- SW with dmem_ready never asserted, MEM_TIMEOUT=16 -> mem_write high exactly 16 cycles; then halt=1, trap=1; retired unchanged; further inputs ignored.
- opcode=1111111 -> halt=1, trap=0 after DECODE. Opcode 0000000 -> halt=1, trap=1. In both cases rst_n pulse returns to IDLE with retired=0.
- CNT_W=4, 17 back-to-back I-type instructions -> retired wraps to 1.
- rst_n low during a MEM cycle of LW -> mem_read drops to 0 asynchronously; outputs all 0.
